// File: rtl/edulent_pkg.sv
// rtl/edulent_pkg.sv - shared types and constants for the 8-bit CPU datapath
// Contents: DATA_W_DEF default datapath width, transfer_cmd_t transfer command
//           encoding, SP_INC/SP_DEC stack pointer step codes.
package edulent_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [3:0] {
        CMD_NONE   = 4'h0,  // no transfer
        CMD_MA_PC  = 4'h1,  // MA <= PC
        CMD_MD_MEM = 4'h2,  // MD <= memory read data
        CMD_IR_MD  = 4'h3,  // IR <= MD
        CMD_MA_MD  = 4'h4,  // MA <= MD
        CMD_ACC_MD = 4'h5,  // A or AP <= MD
        CMD_MA_AP  = 4'h6,  // MA <= AP
        CMD_MA_SP  = 4'h7,  // MA <= SP
        CMD_MD_ACC = 4'h8,  // MD <= A or AP
        CMD_WRITE  = 4'h9,  // M[MA] <= MD
        CMD_ACC_R  = 4'hA,  // A or AP <= R
        CMD_PC_MD  = 4'hB,  // PC <= MD
        CMD_A_IN   = 4'hC,  // A <= input port
        CMD_OUT_A  = 4'hD,  // OUT <= A
        CMD_PC_AP  = 4'hE,  // PC <= AP
        CMD_MD_PC  = 4'hF   // MD <= PC
    } transfer_cmd_t;

    localparam logic [1:0] SP_INC = 2'b01;
    localparam logic [1:0] SP_DEC = 2'b10;

endpackage

// File: rtl/datapath_transfer_unit_sp_unit.sv
// rtl/datapath_transfer_unit_sp_unit.sv - stack pointer register with wrap or saturating guard
// Module sp_unit. Optional feature macro: STACK_GUARD_EN (saturate and flag overflow/underflow).
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_inc_dec_sp[1:0] SP_INC increments, SP_DEC decrements, other codes hold
//   o_sp              current stack pointer
//   o_stack_err       sticky overflow/underflow flag (only with STACK_GUARD_EN)
module sp_unit
    import edulent_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SP_RST = '1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_inc_dec_sp,
`ifdef STACK_GUARD_EN
    output logic              o_stack_err,
`endif
    output logic [DATA_W-1:0] o_sp
);

    logic [DATA_W-1:0] sp;

`ifdef STACK_GUARD_EN
    logic stack_err;

    // The stack grows down from SP_RST, so SP_RST is the ceiling and zero the floor.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sp        <= SP_RST;
            stack_err <= 1'b0;
        end else begin
            case (i_inc_dec_sp)
                SP_INC: begin
                    if (sp == SP_RST) stack_err <= 1'b1;
                    else              sp        <= sp + DATA_W'(1);
                end
                SP_DEC: begin
                    if (sp == '0) stack_err <= 1'b1;
                    else          sp        <= sp - DATA_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_stack_err = stack_err;
`else
    // Plain modulo-2^DATA_W arithmetic: 00-1 wraps to all ones and back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sp <= SP_RST;
        end else begin
            case (i_inc_dec_sp)
                SP_INC:  sp <= sp + DATA_W'(1);
                SP_DEC:  sp <= sp - DATA_W'(1);
                default: ;
            endcase
        end
    end
`endif

    assign o_sp = sp;

endmodule

// File: rtl/datapath_transfer_unit.sv
// rtl/datapath_transfer_unit.sv - register-transfer executor for the 8-bit CPU datapath
// Optional feature macro: STACK_GUARD_EN (adds o_stack_err, saturating SP).
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_transfer_cmd[3:0]         transfer_cmd_t, one destination per cycle
//   i_inc_pc, i_inc_dec_sp      PC increment, SP step (SP_INC/SP_DEC)
//   i_alu_calculate             R <= i_alu_result
//   i_alu_res_to_ap             accumulator select for cmds 5/8/A (1=AP, 0=A)
//   i_mem_write_enable          extra write request
//   i_alu_result, i_mem_rdata, i_in_data   data inputs
//   o_opcode                    IR
//   o_mem_addr, o_mem_wdata, o_mem_we      memory port (MA, MD, write strobe)
//   o_a, o_ap, o_md             ALU operands
//   o_out_data, o_out_valid     OUT register and its load pulse
//   o_in_ack                    pulse after A <- input port
//   o_stack_err                 sticky stack fault (only with STACK_GUARD_EN)
module datapath_transfer_unit
    import edulent_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] PC_RST = '0,
    parameter logic [DATA_W-1:0] SP_RST = '1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_transfer_cmd,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_alu_calculate,
    input  logic              i_alu_res_to_ap,
    input  logic              i_mem_write_enable,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic [DATA_W-1:0] i_in_data,
    output logic [DATA_W-1:0] o_opcode,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_ap,
    output logic [DATA_W-1:0] o_md,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
`ifdef STACK_GUARD_EN
    output logic              o_stack_err,
`endif
    output logic              o_in_ack
);

    transfer_cmd_t     cmd;
    logic [DATA_W-1:0] pc, ma, md, ir, a, ap, r, out_reg, sp;
    logic              out_valid, in_ack;

    assign cmd = transfer_cmd_t'(i_transfer_cmd);

    sp_unit #(
        .DATA_W (DATA_W),
        .SP_RST (SP_RST)
    ) u_sp_unit (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_inc_dec_sp (i_inc_dec_sp),
`ifdef STACK_GUARD_EN
        .o_stack_err  (o_stack_err),
`endif
        .o_sp         (sp)
    );

    // All right-hand sides are pre-edge register values, so e.g. MA<=SP alongside
    // an SP step captures the old SP, and MD<=PC alongside inc_pc captures the old PC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc        <= PC_RST;
            ma        <= '0;
            md        <= '0;
            ir        <= '0;
            a         <= '0;
            ap        <= '0;
            r         <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            in_ack    <= 1'b0;
        end else begin
            out_valid <= (cmd == CMD_OUT_A);
            in_ack    <= (cmd == CMD_A_IN);

            if (i_alu_calculate) r <= i_alu_result;

            // A PC load wins over the increment issued in the same cycle.
            if (cmd == CMD_PC_MD)      pc <= md;
            else if (cmd == CMD_PC_AP) pc <= ap;
            else if (i_inc_pc)         pc <= pc + DATA_W'(1);

            case (cmd)
                CMD_MA_PC:  ma <= pc;
                CMD_MD_MEM: md <= i_mem_rdata;
                CMD_IR_MD:  ir <= md;
                CMD_MA_MD:  ma <= md;
                CMD_ACC_MD: if (i_alu_res_to_ap) ap <= md; else a <= md;
                CMD_MA_AP:  ma <= ap;
                CMD_MA_SP:  ma <= sp;
                CMD_MD_ACC: md <= i_alu_res_to_ap ? ap : a;
                CMD_ACC_R:  if (i_alu_res_to_ap) ap <= r; else a <= r;
                CMD_A_IN:   a <= i_in_data;
                CMD_OUT_A:  out_reg <= a;
                CMD_MD_PC:  md <= pc;
                default: ;
            endcase
        end
    end

    // Combinational so the memory samples MA/MD on the same edge; masked in reset.
    assign o_mem_we    = ((cmd == CMD_WRITE) || i_mem_write_enable) && !i_rst;
    assign o_opcode    = ir;
    assign o_mem_addr  = ma;
    assign o_mem_wdata = md;
    assign o_a         = a;
    assign o_ap        = ap;
    assign o_md        = md;
    assign o_out_data  = out_reg;
    assign o_out_valid = out_valid;
    assign o_in_ack    = in_ack;

endmodule
